// File: rtl/wb_regfile_sb.sv
// Architectural register file at the writeback boundary: two bypassed read ports,
// a pending-write scoreboard driving the decode stall, and a registered debug read port.
module wb_regfile_sb #(
    parameter  int DATA_WIDTH     = 64,
    parameter  int REG_ADDR_WIDTH = 3,
    localparam int NUM_REGS       = 2**REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      w_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_1,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [REG_ADDR_WIDTH-1:0] r_reg_0,
    input  logic [REG_ADDR_WIDTH-1:0] r_reg_1,
    output logic [DATA_WIDTH-1:0]     r_data_0,
    output logic [DATA_WIDTH-1:0]     r_data_1,
    input  logic                      issue_en,
    input  logic                      issue_uses_0,
    input  logic                      issue_uses_1,
    input  logic                      issue_wr,
    input  logic [REG_ADDR_WIDTH-1:0] issue_dst,
    output logic                      stall,
    output logic [NUM_REGS-1:0]       pending_o,
    output logic                      stray_wb_o,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_data,
    output logic [15:0]               stall_cnt
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_clr_mask;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_eff_pend;
    logic                  w_stall;
    logic                  w_accept;

    // Writeback clears its destination bit; this also lets a same-cycle producer unblock consumers
    always_comb begin
        w_clr_mask = '0;
        if (w_reg_en) begin
            w_clr_mask[w_reg_1] = 1'b1;
        end else begin
            w_clr_mask = '0;
        end
    end

    assign w_eff_pend = pending_o & ~w_clr_mask;
    assign w_stall    = issue_en & ((issue_uses_0 & w_eff_pend[r_reg_0]) |
                                    (issue_uses_1 & w_eff_pend[r_reg_1]) |
                                    (issue_wr     & w_eff_pend[issue_dst]));
    assign w_accept   = issue_en & issue_wr & ~w_stall;
    assign stall      = w_stall;

    // Accepted writer marks its destination pending
    always_comb begin
        w_set_mask = '0;
        if (w_accept) begin
            w_set_mask[issue_dst] = 1'b1;
        end else begin
            w_set_mask = '0;
        end
    end

    // Operand read ports with same-cycle writeback bypass
    always_comb begin
        if (w_reg_en && (w_reg_1 == r_reg_0)) begin
            r_data_0 = w_data;
        end else begin
            r_data_0 = r_regs[r_reg_0];
        end
        if (w_reg_en && (w_reg_1 == r_reg_1)) begin
            r_data_1 = w_data;
        end else begin
            r_data_1 = r_regs[r_reg_1];
        end
    end

    // Register array storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_en) begin
            r_regs[w_reg_1] <= w_data;
        end
    end

    // Scoreboard, stray flag, debug capture and stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_o  <= '0;
            stray_wb_o <= 1'b0;
            dbg_data   <= '0;
            stall_cnt  <= 16'd0;
        end else begin
            // set is ORed after the clear so a coincident re-issue keeps the bit
            pending_o <= (pending_o & ~w_clr_mask) | w_set_mask;
            if (w_reg_en && !pending_o[w_reg_1]) begin
                stray_wb_o <= 1'b1;
            end
            dbg_data <= r_regs[dbg_addr];
            if (w_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed-vector bench for wb_regfile_sb: bypass, RAW/WAW stalls, stray writeback,
// debug latency, counter saturation and asynchronous reset.
module tb_wb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        w_reg_en = 1'b0;
    logic [2:0]  w_reg_1 = 3'd0;
    logic [63:0] w_data = 64'd0;
    logic [2:0]  r_reg_0 = 3'd0;
    logic [2:0]  r_reg_1 = 3'd0;
    logic [63:0] r_data_0;
    logic [63:0] r_data_1;
    logic        issue_en = 1'b0;
    logic        issue_uses_0 = 1'b0;
    logic        issue_uses_1 = 1'b0;
    logic        issue_wr = 1'b0;
    logic [2:0]  issue_dst = 3'd0;
    logic        stall;
    logic [7:0]  pending_o;
    logic        stray_wb_o;
    logic [2:0]  dbg_addr = 3'd0;
    logic [63:0] dbg_data;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regfile_sb #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .w_reg_en(w_reg_en), .w_reg_1(w_reg_1), .w_data(w_data),
        .r_reg_0(r_reg_0), .r_reg_1(r_reg_1), .r_data_0(r_data_0), .r_data_1(r_data_1),
        .issue_en(issue_en), .issue_uses_0(issue_uses_0), .issue_uses_1(issue_uses_1),
        .issue_wr(issue_wr), .issue_dst(issue_dst),
        .stall(stall), .pending_o(pending_o), .stray_wb_o(stray_wb_o),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic en, input logic u0, input logic u1,
                             input logic wr, input logic [2:0] dst);
        issue_en = en; issue_uses_0 = u0; issue_uses_1 = u1; issue_wr = wr; issue_dst = dst;
    endtask

    task automatic set_wb(input logic en, input logic [2:0] dst, input logic [63:0] d);
        w_reg_en = en; w_reg_1 = dst; w_data = d;
    endtask

    initial begin
        #1;
        chk("rst_pending", pending_o, 64'd0);
        chk("rst_cnt", stall_cnt, 64'd0);
        chk("rst_dbg", dbg_data, 64'd0);
        chk("rst_stray", stray_wb_o, 64'd0);
        chk("rst_regs", r_data_0, 64'd0);
        #11 reset = 1'b0;
        step();

        // make regs 3 and 5 pending so their writebacks are legitimate
        set_issue(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        #1 chk("iss3_stall", stall, 64'd0);
        step();
        chk("iss3_pend", pending_o, 64'h08);
        set_issue(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        step();
        chk("iss5_pend", pending_o, 64'h28);

        set_issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        set_wb(1'b1, 3'd3, 64'h0123_4567_89AB_CDEF);
        r_reg_0 = 3'd3;
        #1 chk("wb3_bypass", r_data_0, 64'h0123_4567_89AB_CDEF);
        step();
        chk("wb3_pend", pending_o, 64'h20);
        chk("wb3_nostray", stray_wb_o, 64'd0);

        set_wb(1'b1, 3'd5, 64'hAA);
        r_reg_1 = 3'd5;
        dbg_addr = 3'd5;
        #1 chk("rd3_array", r_data_0, 64'h0123_4567_89AB_CDEF);
        chk("wb5_bypass", r_data_1, 64'hAA);
        step();
        chk("wb5_dbg_old", dbg_data, 64'd0);
        chk("wb5_pend", pending_o, 64'd0);
        set_wb(1'b0, 3'd0, 64'd0);
        #1 chk("rd5_array", r_data_1, 64'hAA);
        step();
        chk("wb5_dbg_new", dbg_data, 64'hAA);

        // RAW
        set_issue(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        chk("raw_pend", pending_o, 64'h04);
        set_issue(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        r_reg_0 = 3'd2;
        #1 chk("raw_stall", stall, 64'd1);
        step();
        chk("raw_cnt", stall_cnt, 64'd1);
        set_wb(1'b1, 3'd2, 64'h77);
        #1 chk("raw_wb_stall", stall, 64'd0);
        chk("raw_wb_bypass", r_data_0, 64'h77);
        step();
        chk("raw_wb_pend", pending_o, 64'd0);
        chk("raw_wb_cnt", stall_cnt, 64'd1);
        set_wb(1'b0, 3'd0, 64'd0);

        // WAW and simultaneous set/clear
        set_issue(1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
        step();
        chk("waw_pend", pending_o, 64'h10);
        #1 chk("waw_stall", stall, 64'd1);
        step();
        chk("waw_cnt", stall_cnt, 64'd2);
        set_wb(1'b1, 3'd4, 64'h44);
        #1 chk("waw_wb_stall", stall, 64'd0);
        step();
        chk("setwins_pend", pending_o, 64'h10);
        chk("setwins_stray", stray_wb_o, 64'd0);
        set_wb(1'b0, 3'd0, 64'd0);
        set_issue(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        r_reg_1 = 3'd4;
        #1 chk("raw1_stall", stall, 64'd1);
        step();
        chk("raw1_cnt", stall_cnt, 64'd3);
        set_issue(1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
        #1 chk("noiss_stall", stall, 64'd0);
        step();
        chk("noiss_pend", pending_o, 64'h10);
        chk("noiss_cnt", stall_cnt, 64'd3);
        set_wb(1'b1, 3'd4, 64'h45);
        step();
        chk("clr4_pend", pending_o, 64'd0);

        // stray writeback
        set_wb(1'b1, 3'd6, 64'h66);
        step();
        chk("stray_set", stray_wb_o, 64'd1);
        chk("stray_pend", pending_o, 64'd0);
        set_wb(1'b0, 3'd0, 64'd0);
        r_reg_0 = 3'd6;
        #1 chk("stray_data", r_data_0, 64'h66);
        step();
        chk("stray_hold", stray_wb_o, 64'd1);

        // debug same-edge write
        dbg_addr = 3'd3;
        set_wb(1'b1, 3'd3, 64'hBEEF);
        step();
        chk("dbg_old", dbg_data, 64'h0123_4567_89AB_CDEF);
        set_wb(1'b0, 3'd0, 64'd0);
        step();
        chk("dbg_new", dbg_data, 64'hBEEF);

        // saturation: stall_cnt is 3 here
        set_issue(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        step();
        set_issue(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        r_reg_0 = 3'd1;
        r_reg_1 = 3'd3;
        repeat (65531) @(posedge clk);
        #1 chk("sat_fffe", stall_cnt, 64'hFFFE);
        step();
        chk("sat_ffff", stall_cnt, 64'hFFFF);
        repeat (4468) @(posedge clk);
        #1 chk("sat_hold", stall_cnt, 64'hFFFF);
        chk("sat_stall", stall, 64'd1);

        // async reset between edges
        #2 reset = 1'b1;
        #1;
        chk("arst_pending", pending_o, 64'd0);
        chk("arst_cnt", stall_cnt, 64'd0);
        chk("arst_stray", stray_wb_o, 64'd0);
        chk("arst_dbg", dbg_data, 64'd0);
        chk("arst_stall", stall, 64'd0);
        chk("arst_regs", r_data_1, 64'd0);
        #10 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
Architectural register file that terminates the writeback interface. It consumes the write enable, destination address and data leaving the MEM/WB pipeline register. It serves two combinational operand read ports to decode, with same-cycle write bypass. It also keeps a per-register pending-write scoreboard that generates the decode-stage stall for RAW and WAW hazards.

Parameters:
DATA_WIDTH, 64, register and writeback data width
REG_ADDR_WIDTH, 3, register address width; NUM_REGS = 2**REG_ADDR_WIDTH (derived, not overridable)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
w_reg_en  input  1  writeback enable
w_reg_1  input  REG_ADDR_WIDTH  writeback destination register
w_data  input  DATA_WIDTH  writeback data
r_reg_0  input  REG_ADDR_WIDTH  operand 0 read address
r_reg_1  input  REG_ADDR_WIDTH  operand 1 read address
r_data_0  output  DATA_WIDTH  operand 0 data (combinational)
r_data_1  output  DATA_WIDTH  operand 1 data (combinational)
issue_en  input  1  decode presents an instruction this cycle
issue_uses_0  input  1  instruction reads operand 0
issue_uses_1  input  1  instruction reads operand 1
issue_wr  input  1  instruction writes a register
issue_dst  input  REG_ADDR_WIDTH  instruction destination register
stall  output  1  hold decode (combinational)
pending_o  output  NUM_REGS  scoreboard bits (registered)
stray_wb_o  output  1  sticky flag: writeback to a non-pending register
dbg_addr  input  REG_ADDR_WIDTH  debug read address
dbg_data  output  DATA_WIDTH  debug read data (registered)
stall_cnt  output  16  saturating count of stalled cycles

Behaviour:
- Reset (async, active-high) clears, at assertion and without waiting for a clock edge:
  - all NUM_REGS registers
  - pending_o, stray_wb_o, dbg_data, stall_cnt
- Reset mid-operation discards all in-flight scoreboard state.
- Register array:
  - On each posedge clk with w_reg_en=1, regs[w_reg_1] <= w_data.
  - No hardwired-zero register; all entries are writable.
- Read ports:
  - r_data_x = w_data when w_reg_en=1 and w_reg_1==r_reg_x; otherwise regs[r_reg_x].
  - Zero-cycle latency; bypass applies independently to each port, and both ports may hit it.
- Scoreboard terms:
  - clr_mask = one-hot(w_reg_1) when w_reg_en=1, else 0.
  - eff_pend = pending_o & ~clr_mask.
- Stall equation:
  - stall = issue_en & ((issue_uses_0 & eff_pend[r_reg_0]) | (issue_uses_1 & eff_pend[r_reg_1]) | (issue_wr & eff_pend[issue_dst])).
  - A producer writing back in the same cycle never stalls a consumer; the bypass supplies the data.
- Issue accepted = issue_en & issue_wr & ~stall.
- Scoreboard update each posedge:
  - pending_o <= (pending_o & ~clr_mask) | set_mask, where set_mask = one-hot(issue_dst) when issue is accepted.
  - If set and clear hit the same register in the same cycle, set wins and the bit stays 1.
- Stray writeback:
  - w_reg_en=1 with pending_o[w_reg_1]=0: the data is still written, the scoreboard is unchanged, and stray_wb_o <= 1.
  - stray_wb_o stays set until reset.
- Debug port: dbg_data <= regs[dbg_addr] on every posedge, with one-cycle latency and no bypass.
  - If the same edge also writes that address, dbg_data captures the pre-write value.
- stall_cnt increments on each posedge where stall=1 and saturates at 16'hFFFF.
- issue_en=0 forces stall=0 and blocks any scoreboard set.

Test Plan:
- Reset, then write regs[3]=64'h0123_4567_89AB_CDEF; next cycle r_reg_0=3 -> r_data_0=64'h0123_4567_89AB_CDEF. Same-cycle bypass: w_reg_en=1, w_reg_1=5, w_data=64'hAA, r_reg_1=5 -> r_data_1=64'hAA in that cycle, with regs[5] still old.
- RAW stall: issue dst=2 accepted -> pending_o[2]=1. Next cycle issue uses_0 with r_reg_0=2 -> stall=1 and stall_cnt increments. Cycle with w_reg_en=1, w_reg_1=2, w_data=64'h77 -> stall=0, r_data_0=64'h77, pending_o[2]=0 after the edge.
- WAW plus simultaneous set/clear:
  - With pending_o[4]=1, issue_wr dst=4 -> stall=1.
  - When WB to reg 4 coincides with issue_wr dst=4 -> stall=0, and pending_o[4] remains 1 after the edge.
- Stray writeback: w_reg_en=1, w_reg_1=6 with pending_o=0 -> regs[6] written, stray_wb_o=1 and held until reset.
- Debug and saturation:
  - dbg_addr=3 with a same-edge write to reg 3 -> dbg_data shows the old value, and the new value one cycle later.
  - Hold stall high for 70000 cycles -> stall_cnt=16'hFFFF.
- Async reset mid-stall: assert reset between edges -> pending_o, stall_cnt, stray_wb_o and dbg_data go to 0 immediately, and stall drops to 0.
